// File: rtl/shift_pkg.sv
// Shared types for the shift register unit: operation encoding and FSM states.
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_RSVD = 3'b111
    } shift_mode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift_mode(input shift_mode_t mode);
        return (mode == MODE_SHL) || (mode == MODE_SHR) || (mode == MODE_ROL) ||
               (mode == MODE_ROR) || (mode == MODE_ASR);
    endfunction

endpackage

// File: rtl/dff_sync_rst.sv
// Single storage bit: synchronous active-high reset, load enable, true and
// complementary outputs.
module dff_sync_rst #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q,
    output logic qn
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

    assign qn = ~q;

endmodule

// File: rtl/shift_register_unit.sv
// WIDTH-bit register with parallel load and multi-bit shift/rotate operations
// executed one bit per clock under a start/busy/done handshake.
module shift_register_unit
    import shift_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_mode,
    input  logic [CNT_W-1:0] i_amount,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_ser_in,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_qn,
    output logic             o_ser_out,
    output logic             o_busy,
    output logic             o_done
);

    state_t           state;
    shift_mode_t      mode_q;
    logic [CNT_W-1:0] cnt;
    logic             ser_q;
    logic             busy_q;
    logic             done_q;

    shift_mode_t      req_mode;
    shift_mode_t      op_mode;
    logic [CNT_W-1:0] amount_clamped;
    logic             start_ok;
    logic             start_load;
    logic             start_shift;
    logic             shift_en;
    logic             q_en;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] q_next;
    logic             shifted_out;

    assign req_mode    = shift_mode_t'(i_mode);
    assign start_ok    = (state == IDLE) && i_start;
    assign start_load  = start_ok && (req_mode == MODE_LOAD);
    assign start_shift = start_ok && is_shift_mode(req_mode) && (amount_clamped != '0);
    assign shift_en    = start_shift || (state == SHIFT);
    assign q_en        = shift_en || start_load;

    // The first shift happens on the accepting edge, before mode_q is valid.
    assign op_mode = (state == IDLE) ? req_mode : mode_q;

    always_comb begin
        amount_clamped = i_amount;
        if (i_amount > CNT_W'(WIDTH)) begin
            amount_clamped = CNT_W'(WIDTH);
        end
    end

    always_comb begin
        shifted     = q;
        shifted_out = ser_q;
        case (op_mode)
            MODE_SHL: begin
                shifted     = {q[WIDTH-2:0], i_ser_in};
                shifted_out = q[WIDTH-1];
            end
            MODE_SHR: begin
                shifted     = {i_ser_in, q[WIDTH-1:1]};
                shifted_out = q[0];
            end
            MODE_ROL: begin
                shifted     = {q[WIDTH-2:0], q[WIDTH-1]};
                shifted_out = q[WIDTH-1];
            end
            MODE_ROR: begin
                shifted     = {q[0], q[WIDTH-1:1]};
                shifted_out = q[0];
            end
            MODE_ASR: begin
                shifted     = {q[WIDTH-1], q[WIDTH-1:1]};
                shifted_out = q[0];
            end
            default: begin
                shifted     = q;
                shifted_out = ser_q;
            end
        endcase
    end

    assign q_next = start_load ? i_d : shifted;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_sync_rst #(
            .RESET_VALUE(RESET_VALUE[i])
        ) u_bit (
            .clk(i_clk),
            .rst(i_rst),
            .en (q_en),
            .d  (q_next[i]),
            .q  (q[i]),
            .qn (qn[i])
        );
    end

    // cnt holds the shifts still to do after the current edge's shift.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            mode_q <= MODE_HOLD;
            cnt    <= '0;
            ser_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (shift_en) begin
                ser_q <= shifted_out;
            end
            case (state)
                IDLE: begin
                    if (start_shift) begin
                        mode_q <= req_mode;
                        if (amount_clamped == CNT_W'(1)) begin
                            done_q <= 1'b1;
                        end else begin
                            state  <= SHIFT;
                            cnt    <= amount_clamped - CNT_W'(1);
                            busy_q <= 1'b1;
                        end
                    end else if (start_ok) begin
                        done_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_q       = q;
    assign o_qn      = qn;
    assign o_ser_out = ser_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule

// File: doc/shift_register_unit.md
Name: shift_register_unit

Overview:
- Parametrised successor to the single-bit storage elements: a WIDTH-bit register with parallel load, serial I/O and multi-bit shift/rotate operations executed one bit per clock.
- Driven by a start pulse; reports busy/done.
- Used as the storage/shift datapath element for upcoming serial-interface and ALU exercises.
- Keeps the complementary output convention (o_q / o_qn) of the existing storage cells.

Parameters:
- WIDTH, 8: register width in bits, >= 2.
- RESET_VALUE, '0: value of o_q after reset, WIDTH bits.
- CNT_W, $clog2(WIDTH+1): width of the shift-amount field. Derived; do not override.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset. Synchronous, active-high.
- i_start  input  1  start-operation pulse, sampled in IDLE only.
- i_mode  input  3  operation select, sampled with i_start.
- i_amount  input  CNT_W  number of single-bit shifts, sampled with i_start.
- i_d  input  WIDTH  parallel load data.
- i_ser_in  input  1  serial input bit, sampled live on every shift edge.
- o_q  output  WIDTH  register contents.
- o_qn  output  WIDTH  bitwise inverse of o_q, always.
- o_ser_out  output  1  bit shifted out on the most recent shift.
- o_busy  output  1  multi-cycle shift in progress.
- o_done  output  1  one-cycle completion pulse.

Behaviour:
- Mode encoding:
  - 000 HOLD
  - 001 LOAD
  - 010 SHL (LSB <= i_ser_in)
  - 011 SHR (MSB <= i_ser_in)
  - 100 ROL
  - 101 ROR
  - 110 ASR (MSB replicated)
  - 111 reserved, treated as HOLD
- Reset (i_rst high at a rising edge), effective after that edge:
  - o_q = RESET_VALUE, o_qn = ~RESET_VALUE
  - o_ser_out = 0, o_busy = 0, o_done = 0
  - FSM = IDLE, shift counter = 0
- Reset has priority over everything. Reset mid-operation aborts the operation; no o_done is produced.
- FSM states:
  - IDLE: accepts i_start.
  - SHIFT: counting down remaining shifts.
- Let edge k be the edge in IDLE where i_start = 1:
  - LOAD: o_q <= i_d at edge k. o_done = 1 for the cycle after k. o_busy stays 0.
  - HOLD/reserved, or amount = 0: o_q unchanged. o_done = 1 for the cycle after k. o_busy stays 0.
  - Shift modes with amount N >= 1:
    - First shift at edge k; shifts at edges k .. k+N-1.
    - Mode latched at edge k.
    - o_busy = 1 after edges k .. k+N-2 (N = 1 gives no busy).
    - FSM returns to IDLE after edge k+N-1, with o_done = 1 for exactly that one cycle.
  - Amount > WIDTH is clamped to WIDTH.
- i_start while in SHIFT (o_busy = 1) is ignored; it is not queued.
- i_start in the o_done cycle is accepted normally, allowing back-to-back operations.
- o_ser_out is updated only on shift edges and otherwise holds:
  - SHL/ROL: old MSB.
  - SHR/ROR/ASR: old LSB.
- Rotates ignore i_ser_in.
- After N = WIDTH rotates, o_q equals its original value.
- All outputs are registered or derived combinationally from registers only. No combinational path from inputs to outputs.

Decomposition:
- Package shift_pkg:
  - shift_mode_t: enum logic [2:0] with the encoding above.
  - state_t: enum {IDLE, SHIFT}.
- Sub-module dff_sync_rst: 1-bit D flip-flop with synchronous active-high reset, enable and reset value, providing q/qn. Instantiated WIDTH times via generate for the data register.
- Next-state bit mux, counter and FSM live in the top module.

Test Plan (WIDTH = 8, RESET_VALUE = 0):
1. i_rst = 1 for 2 cycles -> o_q = 8'h00, o_qn = 8'hFF, o_busy = 0, o_done = 0, o_ser_out = 0.
2. LOAD, i_d = 8'hA5, start pulse -> next cycle o_q = A5, o_qn = 5A, o_done = 1 for one cycle, o_busy = 0 throughout.
3. From A5: SHL, amount 3, i_ser_in = 1 -> o_q sequence 4B, 97, 2F; o_ser_out 1, 0, 1; o_busy for 2 cycles; o_done with 2F.
4. From 8'h90: ASR, amount 2 -> o_q C8 then E4; o_ser_out 0, 0; o_done one cycle after the second shift.
5. From 8'h81: ROR, amount 9 (clamped to 8); extra i_start mid-busy -> exactly 8 shifts, final o_q = 81, single o_done, extra start ignored.
6. SHL, amount 5; assert i_rst at the third shift edge -> o_q = 00, o_busy = 0, FSM = IDLE, no o_done; a subsequent LOAD 8'h3C works.
